// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types, opcode constants and decode helpers for the fetch stage
//
// Purpose: opcode map, FSM state encoding, scoreboard entry type and the
//          register-usage decode functions used by fetch_stage and
//          hazard_scoreboard.
// Ports:   none (package).

package fetch_pkg;

  localparam int DEF_AW         = 8;
  localparam int DEF_IW         = 16;
  localparam int DEF_HAZ_DEPTH  = 3;
  localparam int DEF_BR_BUBBLES = 2;

  localparam logic [2:0] OP_R  = 3'b000;
  localparam logic [2:0] OP_I1 = 3'b001;
  localparam logic [2:0] OP_I2 = 3'b010;
  localparam logic [2:0] OP_BR = 3'b100;

  typedef logic [15:0] inst_t;

  localparam inst_t NOP_INST = 16'h0000;

  typedef enum logic {
    RUN     = 1'b0,
    BR_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] dest;
  } sb_entry_t;

  function automatic logic [2:0] op_of(input inst_t inst);
    return inst[15:13];
  endfunction

  function automatic logic is_branch(input inst_t inst);
    return (inst[15:13] == OP_BR);
  endfunction

  // NOP shares opcode 000 with R-type, so it has to be excluded explicitly.
  function automatic logic is_writer(input inst_t inst);
    logic w;
    w = 1'b0;
    if (inst != NOP_INST) begin
      case (inst[15:13])
        OP_R, OP_I1, OP_I2: w = 1'b1;
        default:            w = 1'b0;
      endcase
    end
    return w;
  endfunction

  function automatic logic [2:0] dest_of(input inst_t inst);
    logic [2:0] d;
    if (inst[15:13] == OP_R) d = inst[8:6];
    else                     d = inst[2:0];
    return d;
  endfunction

  // True when any source register of inst equals reg_idx.
  function automatic logic src_match(input inst_t inst, input logic [2:0] reg_idx);
    logic m;
    m = 1'b0;
    if (inst != NOP_INST) begin
      case (inst[15:13])
        OP_R:         m = (inst[2:0] == reg_idx) || (inst[5:3] == reg_idx);
        OP_I1, OP_I2: m = (inst[5:3] == reg_idx);
        default:      m = 1'b0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction memory, decode and branch-resolution signals of the fetch stage
//
// Purpose: bundles every non-clock/reset signal of fetch_stage.
// Ports:   master = fetch stage side (drives imem_addr and IF/ID outputs),
//          slave  = environment side (memory, decode, execute).
//          imem_addr/imem_inst : combinational instruction memory read
//          id_stall            : decode back-pressure
//          br_taken/br_target  : branch resolution from execute
//          id_inst/id_pc/id_valid/haz_bubble : IF/ID register

interface fetch_stage_if #(
  parameter int AW = 8,
  parameter int IW = 16
);
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_inst;
  logic          id_stall;
  logic          br_taken;
  logic [AW-1:0] br_target;
  logic [IW-1:0] id_inst;
  logic [AW-1:0] id_pc;
  logic          id_valid;
  logic          haz_bubble;

  modport master (
    output imem_addr,
    input  imem_inst,
    input  id_stall,
    input  br_taken,
    input  br_target,
    output id_inst,
    output id_pc,
    output id_valid,
    output haz_bubble
  );

  modport slave (
    input  imem_addr,
    output imem_inst,
    output id_stall,
    output br_taken,
    output br_target,
    input  id_inst,
    input  id_pc,
    input  id_valid,
    input  haz_bubble
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - shift register of in-flight destinations with RAW compare
//
// Purpose: remembers the destination register of the last DEPTH issued
//          instructions and flags a RAW hazard for a candidate instruction.
// Ports:   clk, rst_n  : clock, asynchronous active-low reset
//          shift_en    : advance the history by one slot
//          new_entry   : {valid, dest} of the instruction issued this cycle
//          cand_inst   : instruction being considered for issue
//          hazard      : candidate reads a register still in flight

module hazard_scoreboard
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEF_HAZ_DEPTH
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      shift_en,
  input  sb_entry_t new_entry,
  input  inst_t     cand_inst,
  output logic      hazard
);

  sb_entry_t sb [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) sb[i] <= '0;
    end else if (shift_en) begin
      sb[0] <= new_entry;
      for (int i = 1; i < DEPTH; i++) sb[i] <= sb[i-1];
    end
  end

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sb[i].valid && src_match(cand_inst, sb[i].dest)) hazard = 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with run-time RAW and branch bubble insertion
//
// Purpose: owns the PC, fetches from combinational instruction memory and
//          fills the IF/ID register, inserting NOP bubbles for RAW hazards
//          and for a fixed window after every branch.
// Ports:   clk   : rising-edge clock
//          rst_n : asynchronous active-low reset
//          bus   : fetch_stage_if master (imem, stall, branch, IF/ID outputs)

module fetch_stage
  import fetch_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int IW         = DEF_IW,
  parameter int HAZ_DEPTH  = DEF_HAZ_DEPTH,
  parameter int BR_BUBBLES = DEF_BR_BUBBLES
) (
  input  logic           clk,
  input  logic           rst_n,
  fetch_stage_if.master  bus
);

  localparam int CW = $clog2(BR_BUBBLES + 1);

  state_t          state, state_nxt;
  logic [AW-1:0]   pc, pc_nxt;
  logic [CW-1:0]   br_cnt, br_cnt_nxt;
  logic            advance;
  logic            raw_hazard;
  logic            issue;
  logic            raw_bubble;
  sb_entry_t       sb_new;

  assign advance       = !bus.id_stall;
  assign bus.imem_addr = pc;

  // The scoreboard shifts on every non-stalled cycle, bubbles included, so a
  // writer ages out after exactly HAZ_DEPTH cycles whatever fills the pipe.
  hazard_scoreboard #(
    .DEPTH (HAZ_DEPTH)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .shift_en  (advance),
    .new_entry (sb_new),
    .cand_inst (bus.imem_inst),
    .hazard    (raw_hazard)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (advance) begin
      case (state)
        RUN:     if (!raw_hazard && is_branch(bus.imem_inst)) state_nxt = BR_WAIT;
        BR_WAIT: if (br_cnt == CW'(1)) state_nxt = RUN;
        default: state_nxt = RUN;
      endcase
    end
  end

  always_comb begin
    issue      = 1'b0;
    raw_bubble = 1'b0;
    pc_nxt     = pc;
    br_cnt_nxt = br_cnt;
    sb_new     = '0;
    if (advance) begin
      case (state)
        RUN: begin
          if (raw_hazard) begin
            raw_bubble = 1'b1;
          end else begin
            issue        = 1'b1;
            pc_nxt       = pc + AW'(1);
            sb_new.valid = is_writer(bus.imem_inst);
            sb_new.dest  = dest_of(bus.imem_inst);
            if (is_branch(bus.imem_inst)) br_cnt_nxt = CW'(BR_BUBBLES);
          end
        end
        BR_WAIT: begin
          // pc already points at branch+1; a taken branch redirects it but the
          // bubble window still runs to completion.
          br_cnt_nxt = br_cnt - CW'(1);
          if (bus.br_taken) pc_nxt = bus.br_target;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc             <= '0;
      br_cnt         <= '0;
      bus.id_inst    <= '0;
      bus.id_pc      <= '0;
      bus.id_valid   <= 1'b0;
      bus.haz_bubble <= 1'b0;
    end else if (advance) begin
      pc     <= pc_nxt;
      br_cnt <= br_cnt_nxt;
      if (issue) begin
        bus.id_inst    <= bus.imem_inst;
        bus.id_pc      <= pc;
        bus.id_valid   <= 1'b1;
        bus.haz_bubble <= 1'b0;
      end else begin
        bus.id_inst    <= IW'(NOP_INST);
        bus.id_valid   <= 1'b0;
        bus.haz_bubble <= raw_bubble;
      end
    end
  end

  // Execute may only resolve a branch while its bubble window is open.
  br_in_run_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(state == RUN && bus.br_taken && !bus.id_stall));

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage

module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic [15:0] mem [256];
  int          n_checks;
  int          n_errors;

  fetch_stage_if #(.AW(8), .IW(16)) bus ();

  assign bus.imem_inst = mem[bus.imem_addr];

  fetch_stage #(
    .AW         (8),
    .IW         (16),
    .HAZ_DEPTH  (3),
    .BR_BUBBLES (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  // Holds reset across two edges, then releases it just after an edge so the
  // next tick is the first fetch.
  task automatic do_reset();
    rst_n         = 1'b0;
    bus.id_stall  = 1'b0;
    bus.br_taken  = 1'b0;
    bus.br_target = 8'h00;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic check_id(input string tag, input logic [15:0] inst, input logic [7:0] pc,
                          input logic valid, input logic haz);
    check({tag, ".inst"},  32'(bus.id_inst),    32'(inst));
    if (valid) check({tag, ".pc"}, 32'(bus.id_pc), 32'(pc));
    check({tag, ".valid"}, 32'(bus.id_valid),   32'(valid));
    check({tag, ".haz"},   32'(bus.haz_bubble), 32'(haz));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    // Reset state
    clear_mem();
    mem[0] = 16'h2001;  // 001 r1 <- r0
    mem[1] = 16'h2002;  // 001 r2 <- r0
    mem[2] = 16'h4003;  // 010 r3 <- r0
    mem[3] = 16'h012E;  // 000 r4 <- r5,r6
    rst_n  = 1'b0;
    #2;
    check("rst.addr", 32'(bus.imem_addr), 32'h0);
    do_reset();
    check_id("rst", 16'h0000, 8'h00, 1'b0, 1'b0);
    check("rst.id_pc", 32'(bus.id_pc), 32'h0);

    // Independent program: back-to-back issue
    tick(); check_id("ind0", 16'h2001, 8'h00, 1'b1, 1'b0);
    tick(); check_id("ind1", 16'h2002, 8'h01, 1'b1, 1'b0);
    tick(); check_id("ind2", 16'h4003, 8'h02, 1'b1, 1'b0);
    tick(); check_id("ind3", 16'h012E, 8'h03, 1'b1, 1'b0);

    // RAW: r2 written at 0, read at 1 -> three bubbles
    clear_mem();
    mem[0] = 16'h2002;  // 001 r2 <- r0
    mem[1] = 16'h01D0;  // 000 r7 <- r2,r0
    do_reset();
    tick(); check_id("raw0", 16'h2002, 8'h00, 1'b1, 1'b0);
    tick(); check_id("raw_b1", 16'h0000, 8'h00, 1'b0, 1'b1);
    check("raw_b1.addr", 32'(bus.imem_addr), 32'h01);
    tick(); check_id("raw_b2", 16'h0000, 8'h00, 1'b0, 1'b1);
    tick(); check_id("raw_b3", 16'h0000, 8'h00, 1'b0, 1'b1);
    tick(); check_id("raw1", 16'h01D0, 8'h01, 1'b1, 1'b0);

    // Same RAW with a 4-cycle stall after the first bubble
    do_reset();
    tick(); check_id("stl0", 16'h2002, 8'h00, 1'b1, 1'b0);
    tick(); check_id("stl_b1", 16'h0000, 8'h00, 1'b0, 1'b1);
    bus.id_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_id("stl_hold", 16'h0000, 8'h00, 1'b0, 1'b1);
      check("stl_hold.addr", 32'(bus.imem_addr), 32'h01);
    end
    bus.id_stall = 1'b0;
    tick(); check_id("stl_b2", 16'h0000, 8'h00, 1'b0, 1'b1);
    tick(); check_id("stl_b3", 16'h0000, 8'h00, 1'b0, 1'b1);
    tick(); check_id("stl1", 16'h01D0, 8'h01, 1'b1, 1'b0);

    // Branch at 5, taken in the 2nd bubble cycle to 0x20
    clear_mem();
    mem[5]     = 16'h8000;
    mem[6]     = 16'h2001;
    mem[8'h20] = 16'h4003;
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    check_id("brt_pc4", 16'h0000, 8'h04, 1'b1, 1'b0);
    tick(); check_id("brt_br", 16'h8000, 8'h05, 1'b1, 1'b0);
    tick(); check_id("brt_b1", 16'h0000, 8'h00, 1'b0, 1'b0);
    bus.br_taken  = 1'b1;
    bus.br_target = 8'h20;
    tick(); check_id("brt_b2", 16'h0000, 8'h00, 1'b0, 1'b0);
    bus.br_taken  = 1'b0;
    check("brt.addr", 32'(bus.imem_addr), 32'h20);
    tick(); check_id("brt_tgt", 16'h4003, 8'h20, 1'b1, 1'b0);

    // Same branch not taken: falls through to 6
    do_reset();
    for (int i = 0; i < 6; i++) tick();
    check_id("brn_br", 16'h8000, 8'h05, 1'b1, 1'b0);
    tick(); check_id("brn_b1", 16'h0000, 8'h00, 1'b0, 1'b0);
    tick(); check_id("brn_b2", 16'h0000, 8'h00, 1'b0, 1'b0);
    tick(); check_id("brn_fall", 16'h2001, 8'h06, 1'b1, 1'b0);

    // PC wrap: branch to 0xFF, issue there, next fetch is from 0
    clear_mem();
    mem[0]     = 16'h8000;
    mem[8'hFF] = 16'h2001;
    do_reset();
    tick(); check_id("wrp_br", 16'h8000, 8'h00, 1'b1, 1'b0);
    bus.br_taken  = 1'b1;
    bus.br_target = 8'hFF;
    tick();
    bus.br_taken  = 1'b0;
    check("wrp.addr", 32'(bus.imem_addr), 32'hFF);
    tick(); check_id("wrp_b2", 16'h0000, 8'h00, 1'b0, 1'b0);
    tick(); check_id("wrp_ff", 16'h2001, 8'hFF, 1'b1, 1'b0);
    tick(); check_id("wrp_00", 16'h8000, 8'h00, 1'b1, 1'b0);

    // Reset asserted mid-BR_WAIT clears everything at once
    do_reset();
    tick(); check_id("mrst_br", 16'h8000, 8'h00, 1'b1, 1'b0);
    check("mrst.addr_pre", 32'(bus.imem_addr), 32'h01);
    rst_n = 1'b0;
    #1;
    check("mrst.valid", 32'(bus.id_valid), 32'h0);
    check("mrst.addr", 32'(bus.imem_addr), 32'h0);
    check("mrst.inst", 32'(bus.id_inst), 32'h0);
    tick();
    rst_n = 1'b1;
    tick(); check_id("mrst_first", 16'h8000, 8'h00, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage of the pipelined MP. Owns the PC, drives the combinational instruction memory address, and registers the returned 16-bit word into the IF/ID register.
- Detects RAW and branch hazards in hardware and inserts NOP bubbles into IF/ID at run time. Programs can therefore be loaded without statically pre-inserted NOPs.
- Feeds the decode stage and accepts branch resolution from execute.

Parameters:
- AW, 8, instruction address width; PC wraps modulo 2^AW.
- IW, 16, instruction width.
- HAZ_DEPTH, 3, number of in-flight issued instructions checked for RAW hazards.
- BR_BUBBLES, 2, number of NOPs inserted after every branch.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- imem_addr  out  AW  instruction memory address, equal to pc (combinational).
- imem_inst  in  IW  instruction word, combinational read of imem_addr.
- id_stall  in  1  decode cannot accept; freezes the whole stage.
- br_taken  in  1  execute resolved a branch as taken; qualified by !id_stall.
- br_target  in  AW  branch destination, valid with br_taken.
- id_inst  out  IW  IF/ID instruction register.
- id_pc  out  AW  address of id_inst.
- id_valid  out  1  1 = real instruction, 0 = inserted bubble.
- haz_bubble  out  1  registered; 1 when the current id_inst is a RAW bubble.

Behaviour:
- Reset values (asynchronous, active-low): pc=0, id_inst=16'h0000, id_pc=0, id_valid=0, haz_bubble=0, scoreboard all invalid, state=RUN, bubble counter=0.
- Decode rules:
  - NOP is exactly 16'h0000. It neither reads nor writes registers.
  - op = inst[15:13].
  - op 000: writes [8:6]; reads [2:0] and [5:3].
  - op 001/010: writes [2:0]; reads [5:3].
  - op 100: branch.
  - All other opcodes: no reads, no writes.
- Scoreboard: HAZ_DEPTH-entry shift register of {valid, dest[2:0]}.
  - Shifts once per non-stalled cycle.
  - Shifts in the issued instruction's dest (valid=1) if it is a writer, otherwise valid=0.
- id_stall=1: every register holds, including pc, state, counter, scoreboard and IF/ID. br_taken is ignored in that cycle.
- Latency: an instruction at address A appears on id_inst one cycle after pc=A, given no stall or hazard.
- State RUN, each non-stalled cycle:
  - RAW hazard (any source of imem_inst matches a valid scoreboard dest): IF/ID <= bubble (id_inst=0, id_valid=0, haz_bubble=1); pc holds.
  - No hazard: IF/ID <= {imem_inst, pc, valid=1}, haz_bubble=0, pc <= pc+1 (255 wraps to 0).
  - If the issued instruction is op 100: go to BR_WAIT with counter=BR_BUBBLES.
- State BR_WAIT, each non-stalled cycle:
  - IF/ID <= bubble with haz_bubble=0. Counter decrements.
  - When counter reaches 1, return to RUN.
  - br_taken in any BR_WAIT cycle: pc <= br_target immediately. The window still completes all BR_BUBBLES bubbles. Multiple pulses: last wins.
  - No br_taken in the window: fetch continues at the branch address + 1.
- br_taken in RUN is ignored. It is a protocol error and is asserted against in simulation.
- Bubbles are not hazard-checked and never stall pc.
- Reset asserted mid-branch or mid-hazard returns all state to reset values at once. The first fetch after release is from address 0.

Decomposition:
- Shared package fetch_pkg:
  - Opcode constants OP_R=3'b000, OP_I1=3'b001, OP_I2=3'b010, OP_BR=3'b100; NOP_INST=16'h0000.
  - State encoding RUN/BR_WAIT.
  - Decode functions is_writer, dest_of, src_match.
- One sub-module, hazard_scoreboard: the shift register plus the match compare. Inputs: shift enable, new entry, candidate instruction. Output: hazard.

Test Plan:
- Independent program (mem[0..3] = 001 writes r1, 001 writes r2, 010 writes r3, 000 writes r4 with sources r5,r6) -> id_pc 0,1,2,3 on consecutive cycles, id_valid=1, no bubbles.
- mem[0]=001 dest r2, mem[1]=000 src [5:3]=r2 -> exactly 3 bubbles with haz_bubble=1, then id_inst=mem[1], id_pc=1.
- Branch at address 5, br_taken with br_target=8'h20 in the 2nd bubble cycle -> two bubbles, then id_pc=0x20. Same test not taken -> id_pc=6.
- id_stall held 4 cycles during a RAW bubble sequence -> outputs frozen; total bubble count still 3.
- pc=255 issuing a non-branch -> next id_pc=0 (wrap).
- rst_n pulled low mid-BR_WAIT -> id_valid=0 and pc=0 immediately; after release, id_pc=0 one cycle later.
